// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel 3x3 window path.
// Pixel and window types plus window index names.
package sobel_pkg;

  typedef logic [7:0] pixel_t;
  typedef pixel_t [0:8] window_t;

  localparam int WIN_SIZE = 9;

  localparam int TL = 0;
  localparam int TM = 1;
  localparam int TR = 2;
  localparam int ML = 3;
  localparam int MM = 4;
  localparam int MR = 5;
  localparam int BL = 6;
  localparam int BM = 7;
  localparam int BR = 8;

endpackage

// File: rtl/sobel_line_buffer.sv
// Single-port line memory, combinational read-before-write.
// Ports: clk, i_we, i_addr, i_wdata -> o_rdata (old word at i_addr).
module sobel_line_buffer #(
  parameter int DEPTH = 64,
  parameter int W     = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

endmodule

// File: rtl/sobel_window_builder.sv
// Builds a 3x3 window from a raster pixel stream for the gradient blocks.
// Ports: clk, rst, pixel_in/pixel_valid/sof in; windowBuffer,
// start_calculations, frame_done out.
module sobel_window_builder
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic    clk,
  input  logic    rst,
  input  pixel_t  pixel_in,
  input  logic    pixel_valid,
  input  logic    sof,
  output window_t windowBuffer,
  output logic    start_calculations,
  output logic    frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  window_t       r_win;
  logic          r_start;
  logic          r_done;

  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic          w_last_col;
  logic          w_last_row;
  logic [15:0]   w_lb_rd;
  logic [15:0]   w_lb_wr;
  pixel_t        w_top;
  pixel_t        w_mid;

  // sof relabels the accepted pixel as (0,0) on the spot.
  assign w_col      = sof ? '0 : r_col;
  assign w_row      = sof ? '0 : r_row;
  assign w_last_col = (w_col == CW'(IMG_WIDTH - 1));
  assign w_last_row = (w_row == RW'(IMG_HEIGHT - 1));

  // One wide memory: upper byte is lb0 (two rows up), lower is lb1.
  assign w_top   = w_lb_rd[15:8];
  assign w_mid   = w_lb_rd[7:0];
  assign w_lb_wr = {w_mid, pixel_in};

  sobel_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .W     (16),
    .AW    (CW)
  ) u_lb (
    .clk     (clk),
    .i_we    (pixel_valid && !rst),
    .i_addr  (w_col),
    .i_wdata (w_lb_wr),
    .o_rdata (w_lb_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col   <= '0;
      r_row   <= '0;
      r_win   <= '0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      if (pixel_valid) begin
        r_win[TL] <= r_win[TM];
        r_win[TM] <= r_win[TR];
        r_win[TR] <= w_top;
        r_win[ML] <= r_win[MM];
        r_win[MM] <= r_win[MR];
        r_win[MR] <= w_mid;
        r_win[BL] <= r_win[BM];
        r_win[BM] <= r_win[BR];
        r_win[BR] <= pixel_in;
        r_start <= (w_row >= RW'(2)) && (w_col >= CW'(2));
        if (w_last_col) begin
          r_col <= '0;
          if (w_last_row) begin
            r_row  <= '0;
            r_done <= 1'b1;
          end else begin
            r_row <= w_row + RW'(1);
          end
        end else begin
          r_col <= w_col + CW'(1);
          r_row <= w_row;
        end
      end
    end
  end

  assign windowBuffer       = r_win;
  assign start_calculations = r_start;
  assign frame_done         = r_done;

endmodule
